elevator_ctrl: RTL and testbench
================================

ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 Parameter DOOR_TICKS, default 3, number of slow ticks the door SHALL stay open (legal range 1..15).
REQ-002 clk  input  1  system clock; every flop SHALL be clocked on its rising edge, and no other clock SHALL be used.
REQ-003 rst  input  1  reset, synchronous and active-low; rst=0 at a rising clk edge SHALL reset the block.
REQ-004 clk_div_1  input  1  slow square wave from the clock divider; it SHALL be treated as data and never used as a clock.
REQ-005 call_req  input  4  floor request buttons, one bit per floor 0..3, level or pulse; one clk cycle high SHALL suffice.
REQ-006 floor  output  2  current floor, 0..3.
REQ-007 door_open  output  1  high while in DOOR_OPEN.
REQ-008 moving  output  1  high while in MOVE_UP or MOVE_DOWN.
REQ-009 dir_up  output  1  last or current travel direction, 1 = up.
REQ-010 pending  output  4  latched outstanding requests.

Function
REQ-011 Tick: clk_div_1 SHALL pass a 2-flop synchronizer, then a rising-edge detector; tick SHALL be high exactly one clk cycle, on the 3rd clk edge after clk_div_1 rises. A falling edge SHALL produce no tick.
REQ-012 Request latch: each cycle, pending <= (pending | call_req) & ~clr, with clr = one-hot(floor) while the state is DOOR_OPEN and 0 otherwise.
REQ-013 FSM states: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN; the state register and all outputs SHALL be registered.
REQ-014 IDLE: if pending[floor], go to DOOR_OPEN on the next edge without waiting for a tick.
REQ-015 IDLE, otherwise: let above = any pending bit above floor, below = any pending bit below floor.
- If dir_up=1: above goes to MOVE_UP, else below goes to MOVE_DOWN with dir_up<=0.
- If dir_up=0: below goes to MOVE_DOWN, else above goes to MOVE_UP with dir_up<=1.
- If neither, stay in IDLE.
REQ-016 MOVE_UP: floor SHALL change only on a tick, floor<=floor+1.
- Same edge: if the pending bit of the new floor is set, go to DOOR_OPEN.
- Else if any pending bit above the new floor is set, stay in MOVE_UP.
- Else go to IDLE.
REQ-017 MOVE_DOWN: mirror of REQ-016, with floor<=floor-1.
REQ-018 Floor SHALL never wrap; MOVE_UP is never entered at floor 3 and MOVE_DOWN is never entered at floor 0.
REQ-019 DOOR_OPEN: a 4-bit door_cnt SHALL increment on each tick. The tick that occurs when door_cnt=DOOR_TICKS-1 SHALL move to IDLE and clear door_cnt.
REQ-020 door_cnt SHALL be 0 on every entry to DOOR_OPEN, so the door is open for DOOR_TICKS ticks.
REQ-021 A call_req for the current floor during DOOR_OPEN, including on the exit edge, SHALL be absorbed: no re-open and no pending bit left behind.
REQ-022 A call_req arriving on the same edge as a floor change SHALL be latched; if it targets the new floor, it SHALL be served by the next IDLE evaluation.
REQ-023 In MOVE_UP and MOVE_DOWN, pending bits SHALL only be set and never cleared.

Reset
REQ-024 On rst=0 at a clk edge, the following SHALL take effect the same edge:
- state=IDLE, floor=0, dir_up=1, door_open=0, moving=0, pending=0, door_cnt=0, synchronizer and edge flops=0.
REQ-025 call_req and clk_div_1 SHALL be ignored while rst=0; reset mid-move or mid-door SHALL abort immediately, without completing the move.
REQ-026 After rst returns to 1, a clk_div_1 already high SHALL NOT generate a tick until it falls and rises again.

Verification
REQ-027 Reset, then call_req=4'b1000 for 1 cycle -> moving=1, dir_up=1; floor steps 1,2,3 on 3 consecutive ticks; door_open=1 at floor 3 for 3 ticks; then IDLE, pending=0.
REQ-028 At floor 0, call_req=4'b0001 -> door_open=1 on the second edge with no tick; closes after 3 ticks.
REQ-029 At floor 3 going idle, pending=4'b0101 -> MOVE_DOWN; stops at 2 (door), then continues to 0 (door); dir_up=0 throughout.
REQ-030 During DOOR_OPEN at floor 2, pulse call_req=4'b0100 on the exit edge -> IDLE follows, no re-open, pending[2]=0.
REQ-031 Hold clk_div_1 high for 10 cycles -> exactly one tick; falling edge -> no tick; rst=0 while moving at floor 1 -> floor=0, moving=0, pending=0 on the next edge.

Source files
------------

// File: rtl/elevator_ctrl.sv
// Four-floor elevator controller: latches floor calls, travels toward them on
// synchronized slow-clock ticks and holds the door open for DOOR_TICKS ticks.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | parked, choosing to open, travel or wait
// MOVE_UP   | travelling up, one floor per tick
// MOVE_DOWN | travelling down, one floor per tick
// DOOR_OPEN | door open at current floor, counting ticks
module elevator_ctrl #(
  parameter int DOOR_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_div_1,
  input  logic [3:0] call_req,
  output logic [1:0] floor,
  output logic       door_open,
  output logic       moving,
  output logic       dir_up,
  output logic [3:0] pending
);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

  localparam logic [3:0] LAST_TICK = 4'(DOOR_TICKS - 1);

  state_t     state, state_n;
  logic [1:0] floor_n, floor_up, floor_dn;
  logic       dir_n;
  logic [3:0] door_cnt, door_cnt_n;
  logic [3:0] clr, oh_floor, mask_above, mask_below, mask_above_up, mask_below_dn;
  logic       sync1, sync2, sync3, tick;
  logic       vld1, vld2, armed;

  // armed blocks a tick until the synchronized input has really been seen low,
  // so a divider already high when reset releases does not fake a rising edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync3     <= 1'b0;
      vld1      <= 1'b0;
      vld2      <= 1'b0;
      armed     <= 1'b0;
      tick      <= 1'b0;
      state     <= IDLE;
      floor     <= 2'd0;
      dir_up    <= 1'b1;
      door_cnt  <= 4'd0;
      pending   <= 4'd0;
      door_open <= 1'b0;
      moving    <= 1'b0;
    end else begin
      sync1     <= clk_div_1;
      sync2     <= sync1;
      sync3     <= sync2;
      vld1      <= 1'b1;
      vld2      <= vld1;
      armed     <= armed | (vld2 & ~sync2);
      tick      <= sync2 & ~sync3 & armed;
      state     <= state_n;
      floor     <= floor_n;
      dir_up    <= dir_n;
      door_cnt  <= door_cnt_n;
      pending   <= (pending | call_req) & ~clr;
      door_open <= (state_n == DOOR_OPEN);
      moving    <= (state_n == MOVE_UP) || (state_n == MOVE_DOWN);
    end
  end

  always_comb begin
    state_n       = state;
    floor_n       = floor;
    dir_n         = dir_up;
    door_cnt_n    = 4'd0;
    clr           = 4'd0;
    floor_up      = floor + 2'd1;
    floor_dn      = floor - 2'd1;
    oh_floor      = 4'b0001 << floor;
    mask_above    = 4'b1110 << floor;
    mask_below    = oh_floor - 4'd1;
    mask_above_up = 4'b1110 << floor_up;
    mask_below_dn = (4'b0001 << floor_dn) - 4'd1;
    case (state)
      IDLE: begin
        if (pending[floor]) begin
          state_n = DOOR_OPEN;
        end else if (dir_up) begin
          if (|(pending & mask_above)) begin
            state_n = MOVE_UP;
          end else if (|(pending & mask_below)) begin
            state_n = MOVE_DOWN;
            dir_n   = 1'b0;
          end
        end else begin
          if (|(pending & mask_below)) begin
            state_n = MOVE_DOWN;
          end else if (|(pending & mask_above)) begin
            state_n = MOVE_UP;
            dir_n   = 1'b1;
          end
        end
      end
      MOVE_UP: begin
        if (floor == 2'd3) begin
          state_n = IDLE;
        end else if (tick) begin
          floor_n = floor_up;
          if (pending[floor_up])              state_n = DOOR_OPEN;
          else if (|(pending & mask_above_up)) state_n = MOVE_UP;
          else                                 state_n = IDLE;
        end
      end
      MOVE_DOWN: begin
        if (floor == 2'd0) begin
          state_n = IDLE;
        end else if (tick) begin
          floor_n = floor_dn;
          if (pending[floor_dn])              state_n = DOOR_OPEN;
          else if (|(pending & mask_below_dn)) state_n = MOVE_DOWN;
          else                                 state_n = IDLE;
        end
      end
      DOOR_OPEN: begin
        clr        = oh_floor;
        door_cnt_n = door_cnt;
        if (tick) begin
          if (door_cnt == LAST_TICK) begin
            state_n    = IDLE;
            door_cnt_n = 4'd0;
          end else begin
            door_cnt_n = door_cnt + 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl: a table of multi-cycle stimulus records with the
// outputs expected at the end of each, plus a hand sequence for tick latency.
module tb_elevator_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clk_div_1 = 1'b0;
  logic [3:0] call_req = 4'd0;
  logic [1:0] floor;
  logic       door_open, moving, dir_up;
  logic [3:0] pending;

  elevator_ctrl #(.DOOR_TICKS(3)) dut (
    .clk(clk), .rst(rst), .clk_div_1(clk_div_1), .call_req(call_req),
    .floor(floor), .door_open(door_open), .moving(moving),
    .dir_up(dir_up), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] floor;
    logic       door;
    logic       mov;
    logic       dir;
    logic [3:0] pend;
  } exp_t;

  // rst value, call pattern and the cycle it is pulsed on, cycles clk_div_1 is
  // high from the start, record length, then outputs after the last edge
  typedef struct {
    logic       r;
    logic [3:0] call;
    int         call_cyc;
    int         clk_hi;
    int         cycles;
    exp_t       e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic add(input logic r, input logic [3:0] call, input int cc,
                     input int hi, input int cyc, input logic [1:0] f,
                     input logic d, input logic m, input logic di,
                     input logic [3:0] p);
    vec_t v;
    v.r = r; v.call = call; v.call_cyc = cc; v.clk_hi = hi; v.cycles = cyc;
    v.e.floor = f; v.e.door = d; v.e.mov = m; v.e.dir = di; v.e.pend = p;
    vecs.push_back(v);
  endtask

  // one full tick: divider high for 3 cycles, low for 5
  task automatic add_tick(input logic [1:0] f, input logic d, input logic m,
                          input logic di, input logic [3:0] p);
    add(1'b1, 4'd0, -1, 3, 8, f, d, m, di, p);
  endtask

  task automatic compare_pop(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    n_total++;
    if ({floor, door_open, moving, dir_up, pending} ===
        {e.floor, e.door, e.mov, e.dir, e.pend}) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got floor=%0d door=%b moving=%b dir_up=%b pending=%b, required floor=%0d door=%b moving=%b dir_up=%b pending=%b",
               name, floor, door_open, moving, dir_up, pending,
               e.floor, e.door, e.mov, e.dir, e.pend);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] call, input logic cdiv);
    @(negedge clk);
    rst = r; call_req = call; clk_div_1 = cdiv;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] f, input logic d, input logic m,
                          input logic di, input logic [3:0] p);
    exp_t e;
    e.floor = f; e.door = d; e.mov = m; e.dir = di; e.pend = p;
    sb.push_back(e);
  endtask

  initial begin
    // reset, with calls and divider activity ignored
    add(1'b0, 4'b1111, 0, 3, 8,  2'd0, 0, 0, 1, 4'b0000);
    // call to floor 3 from floor 0
    add(1'b1, 4'b1000, 0, 0, 2,  2'd0, 0, 1, 1, 4'b1000);
    add_tick(2'd1, 0, 1, 1, 4'b1000);
    add_tick(2'd2, 0, 1, 1, 4'b1000);
    add_tick(2'd3, 1, 0, 1, 4'b0000);
    add_tick(2'd3, 1, 0, 1, 4'b0000);
    add_tick(2'd3, 1, 0, 1, 4'b0000);
    add_tick(2'd3, 0, 0, 1, 4'b0000);
    // from floor 3, calls at 2 and 0
    add(1'b1, 4'b0101, 0, 0, 2,  2'd3, 0, 1, 0, 4'b0101);
    add_tick(2'd2, 1, 0, 0, 4'b0001);
    add_tick(2'd2, 1, 0, 0, 4'b0001);
    add_tick(2'd2, 1, 0, 0, 4'b0001);
    // own-floor call on the door exit edge is absorbed
    add(1'b1, 4'b0100, 3, 3, 8,  2'd2, 0, 1, 0, 4'b0001);
    add_tick(2'd1, 0, 1, 0, 4'b0001);
    add_tick(2'd0, 1, 0, 0, 4'b0000);
    add_tick(2'd0, 1, 0, 0, 4'b0000);
    add_tick(2'd0, 1, 0, 0, 4'b0000);
    add_tick(2'd0, 0, 0, 0, 4'b0000);
    // call at the current floor opens without a tick
    add(1'b1, 4'b0001, 0, 0, 2,  2'd0, 1, 0, 0, 4'b0001);
    add(1'b1, 4'b0000, -1, 0, 1, 2'd0, 1, 0, 0, 4'b0000);
    add_tick(2'd0, 1, 0, 0, 4'b0000);
    add_tick(2'd0, 1, 0, 0, 4'b0000);
    add_tick(2'd0, 0, 0, 0, 4'b0000);
    // call latched on the same edge as a floor change
    add(1'b1, 4'b0100, 0, 0, 2,  2'd0, 0, 1, 1, 4'b0100);
    add(1'b1, 4'b0010, 3, 3, 8,  2'd1, 0, 1, 1, 4'b0110);
    add_tick(2'd2, 1, 0, 1, 4'b0010);
    add_tick(2'd2, 1, 0, 1, 4'b0010);
    add_tick(2'd2, 1, 0, 1, 4'b0010);
    add_tick(2'd2, 0, 1, 0, 4'b0010);
    add_tick(2'd1, 1, 0, 0, 4'b0000);
    add_tick(2'd1, 1, 0, 0, 4'b0000);
    add_tick(2'd1, 1, 0, 0, 4'b0000);
    add_tick(2'd1, 0, 0, 0, 4'b0000);
    // divider held high for 10 cycles gives one tick only
    add(1'b1, 4'b0010, 0, 0, 2,  2'd1, 1, 0, 0, 4'b0010);
    add(1'b1, 4'b0000, -1, 10, 15, 2'd1, 1, 0, 0, 4'b0000);
    add_tick(2'd1, 1, 0, 0, 4'b0000);
    add_tick(2'd1, 0, 0, 0, 4'b0000);
    // reset while moving at floor 1, released with the divider already high
    add(1'b1, 4'b1000, 0, 0, 2,  2'd1, 0, 1, 1, 4'b1000);
    add(1'b0, 4'b0000, -1, 1, 1, 2'd0, 0, 0, 1, 4'b0000);
    add(1'b1, 4'b1000, 0, 6, 6,  2'd0, 0, 1, 1, 4'b1000);
    add(1'b1, 4'b0000, -1, 0, 4, 2'd0, 0, 1, 1, 4'b1000);
    add_tick(2'd1, 0, 1, 1, 4'b1000);
    add_tick(2'd2, 0, 1, 1, 4'b1000);
    add_tick(2'd3, 1, 0, 1, 4'b0000);
    add_tick(2'd3, 1, 0, 1, 4'b0000);
    add_tick(2'd3, 1, 0, 1, 4'b0000);
    add_tick(2'd3, 0, 0, 1, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      sb.push_back(vecs[i].e);
      for (int c = 0; c < vecs[i].cycles; c++) begin
        @(negedge clk);
        rst       = vecs[i].r;
        call_req  = (c == vecs[i].call_cyc) ? vecs[i].call : 4'd0;
        clk_div_1 = (c < vecs[i].clk_hi);
        @(posedge clk);
      end
      #1;
      compare_pop($sformatf("vec%0d", i));
    end

    // tick latency: the door closes on the 4th edge after the final rise
    drive(1'b1, 4'b1000, 1'b0);
    drive(1'b1, 4'b0000, 1'b0);
    push_exp(2'd3, 1, 0, 1, 4'b1000);
    compare_pop("open_at_floor3");
    for (int t = 0; t < 2; t++) begin
      repeat (3) drive(1'b1, 4'b0000, 1'b1);
      repeat (5) drive(1'b1, 4'b0000, 1'b0);
    end
    push_exp(2'd3, 1, 0, 1, 4'b0000);
    compare_pop("door_after_two_ticks");
    repeat (3) drive(1'b1, 4'b0000, 1'b1);
    push_exp(2'd3, 1, 0, 1, 4'b0000);
    compare_pop("door_edge3_still_open");
    drive(1'b1, 4'b0000, 1'b0);
    push_exp(2'd3, 0, 0, 1, 4'b0000);
    compare_pop("door_edge4_closed");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
